// File: rtl/ldl_cdc_ring_sink_v1_if.sv
// Sink-side bus of the ring CDC sink: change-detect input, buffered output, overflow status.
// drop_cnt exists only when LDL_CDC_RING_SINK_DROPCNT_EN is defined.
interface ldl_cdc_ring_sink_v1_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic [LW-1:0]    level;
  logic             ovf;
  logic             ovf_clr;
`ifdef LDL_CDC_RING_SINK_DROPCNT_EN
  logic [CNTW-1:0]  drop_cnt;

  modport master (
    input  din, dout_rdy, ovf_clr,
    output dout, dout_vld, level, ovf, drop_cnt
  );
  modport slave (
    output din, dout_rdy, ovf_clr,
    input  dout, dout_vld, level, ovf, drop_cnt
  );
`else
  modport master (
    input  din, dout_rdy, ovf_clr,
    output dout, dout_vld, level, ovf
  );
  modport slave (
    output din, dout_rdy, ovf_clr,
    input  dout, dout_vld, level, ovf
  );
`endif
endinterface

// File: rtl/ldl_cdc_ring_sink_v1.sv
// Ring sink: every change of din is an event pushed into a circular FIFO; overflow drops are
// flagged sticky. Define LDL_CDC_RING_SINK_DROPCNT_EN to add the saturating drop counter.
module ldl_cdc_ring_sink_v1 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input logic                    clk,
  input logic                    rst,
  ldl_cdc_ring_sink_v1_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] prv;
  logic [PW-1:0]    wr, rd;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             evt, full, empty, pop, wen, drop;

  assign evt   = (bus.din != prv);
  assign empty = (wr == rd);
  assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign pop   = !empty && bus.dout_rdy;
  // A pop frees the head slot this edge, so a push into a full buffer still lands.
  assign wen   = evt && (!full || pop);
  assign drop  = evt && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prv <= '0;
      wr  <= '0;
      rd  <= '0;
    end else begin
      prv <= bus.din;
      if (wen) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wen) mem[wr[AW-1:0]] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              bus.ovf <= 1'b0;
    else if (drop)        bus.ovf <= 1'b1;
    else if (bus.ovf_clr) bus.ovf <= 1'b0;
  end

`ifdef LDL_CDC_RING_SINK_DROPCNT_EN
  // Clear restarts the count, so a coincident drop leaves exactly one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.drop_cnt <= '0;
    else if (bus.ovf_clr)
      bus.drop_cnt <= drop ? CNTW'(1) : '0;
    else if (drop && !(&bus.drop_cnt))
      bus.drop_cnt <= bus.drop_cnt + 1'b1;
  end
`endif

  assign bus.dout     = mem[rd[AW-1:0]];
  assign bus.dout_vld = !empty;
  assign bus.level    = wr - rd;
endmodule

// File: doc/ldl_cdc_ring_sink_v1.md
LDL_CDC_RING_SINK_V1 -- requirements
Module: LDL_cdc_ring_sink_v1

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL match the upstream ring data width.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of 2, minimum 2.
REQ-003 Parameter CNTW, default 8: drop-counter width.
REQ-004 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-high.
REQ-006 Port din, input, WIDTH: ring output word, already in the clk domain.
REQ-007 Port dout, output, WIDTH: head-of-buffer word.
REQ-008 Port dout_vld, output, 1: dout holds a valid word.
REQ-009 Port dout_rdy, input, 1: consumer accepts dout.
REQ-010 Port level, output, $clog2(DEPTH)+1: number of occupied entries.
REQ-011 Port ovf, output, 1: sticky overflow flag.
REQ-012 Port ovf_clr, input, 1: clears ovf and drop_cnt.
REQ-013 Port drop_cnt, output, CNTW: dropped-event count; present only under REQ-030.

Function
REQ-014 Prev register prv SHALL load din every cycle.
REQ-015 An event SHALL be asserted in any cycle where din != prv; repeated equal words are not events.
REQ-016 push = event; pop = dout_vld & dout_rdy.
REQ-017 Buffer SHALL be a circular FIFO with wr/rd pointers of $clog2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-018 Write SHALL occur when push & (!full | pop); the entry stored is din.
REQ-019 Latency: an event sampled at edge N SHALL make dout_vld=1 with dout=that word after edge N; there is no same-cycle bypass.
REQ-020 dout_vld SHALL equal !empty; dout SHALL be the entry at rd pointer; dout is don't-care when empty.
REQ-021 Simultaneous push and pop when full: both take effect, and level is unchanged.
REQ-022 Simultaneous push and pop when empty: push only, because pop is impossible.
REQ-023 Drop: when push & full & !pop, the word SHALL be discarded, ovf set to 1, and drop_cnt incremented.
REQ-024 drop_cnt SHALL saturate at all-ones and not wrap.
REQ-025 ovf_clr SHALL zero ovf and drop_cnt on the next edge; if a drop occurs in the same cycle, ovf=1 and drop_cnt=1.
REQ-026 Pointers SHALL wrap modulo 2*DEPTH; level = wr - rd, with range 0..DEPTH.

Reset
REQ-027 While rst=1: prv=0, pointers=0, level=0, dout_vld=0, ovf=0, drop_cnt=0; buffer contents are not reset.
REQ-028 Reset mid-operation SHALL discard all buffered words.
REQ-029 After release, an upstream ring holding reset value 0 SHALL produce no event.

Configuration
REQ-030 Macro LDL_CDC_RING_SINK_DROPCNT_EN:
- Defined: drop_cnt port and counter exist per REQ-023..025.
- Undefined: port and counter are absent; ovf behaviour is unchanged.

Verification
REQ-031 Reset, din held 0 for 10 cycles -> dout_vld=0, level=0, ovf=0.
REQ-032 din 0->0x11 at edge 5, dout_rdy=1 -> dout_vld=1, dout=0x11 after edge 5; popped at edge 6; level returns to 0.
REQ-033 DEPTH=4, dout_rdy=0, din steps 1,2,3,4,5,6 on consecutive cycles:
- level=4, ovf=1, drop_cnt=2.
- Reads give 1,2,3,4.
REQ-034 Buffer full, din changes and dout_rdy=1 in the same cycle -> level stays 4, no drop, and the new word is last out.
REQ-035 CNTW=2, 5 drops -> drop_cnt=3; ovf_clr coincident with a further drop -> ovf=1, drop_cnt=1.
REQ-036 rst pulsed with 3 words buffered -> dout_vld=0 immediately; after release, din=prv gives no event.
